// File: rtl/lsu_mem_stage.sv
// Load/store memory stage: one valid/ready memory op at a time over a simple request/response bus.
// Optional macro LSU_MISALIGN_CHECK_EN rejects misaligned half/word accesses instead of masking them.
module lsu_mem_stage #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [1:0]            i_mren,
  input  logic [1:0]            i_mwen,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic [DATA_W-1:0]     i_wdata,
  output logic                  o_resp_valid,
  input  logic                  i_resp_ready,
  output logic [DATA_W-1:0]     o_rdata,
  output logic                  o_resp_err,
  output logic                  o_mem_req_valid,
  input  logic                  i_mem_req_ready,
  output logic                  o_mem_we,
  output logic [ADDR_W-1:0]     o_mem_addr,
  output logic [DATA_W-1:0]     o_mem_wdata,
  output logic [DATA_W/8-1:0]   o_mem_wstrb,
  input  logic                  i_mem_rvalid,
  input  logic [DATA_W-1:0]     i_mem_rdata
);

  typedef enum logic [1:0] {StIdle, StBusReq, StBusWait, StResp} state_e;

  localparam logic [1:0] SzByte = 2'b01;
  localparam logic [1:0] SzHalf = 2'b10;
  localparam logic [1:0] SzWord = 2'b11;

  state_e              r_state;
  state_e              w_state_nxt;

  logic                r_is_rd;
  logic [1:0]          r_size;
  logic [1:0]          r_lane;
  logic                r_resp_valid;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic                r_mem_req_valid;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W/8-1:0] r_mem_wstrb;

  logic                w_accept;
  logic                w_is_rd;
  logic [1:0]          w_size;
  logic                w_illegal;
  logic                w_noop;
  logic                w_misalign_err;
  logic                w_skip_bus;
  logic [1:0]          w_lane;
  logic [DATA_W/8-1:0] w_wstrb;
  logic [DATA_W-1:0]   w_wdata_lanes;
  logic [7:0]          w_rd_byte;
  logic [15:0]         w_rd_half;
  logic [DATA_W-1:0]   w_load_data;

  assign w_accept  = i_req_valid && (r_state == StIdle);
  assign w_is_rd   = (i_mren != 2'b00);
  assign w_size    = w_is_rd ? i_mren : i_mwen;
  assign w_illegal = (i_mren != 2'b00) && (i_mwen != 2'b00);
  assign w_noop    = (i_mren == 2'b00) && (i_mwen == 2'b00);

`ifdef LSU_MISALIGN_CHECK_EN
  assign w_misalign_err = ((w_size == SzHalf) && i_addr[0]) ||
                          ((w_size == SzWord) && (i_addr[1:0] != 2'b00));
`else
  assign w_misalign_err = 1'b0;
`endif

  assign w_skip_bus = w_illegal || w_noop || w_misalign_err;

  // Low address bits a half/word access cannot use are dropped before lane selection.
  always_comb begin
    w_lane = i_addr[1:0];
    if (w_size == SzHalf) begin
      w_lane[0] = 1'b0;
    end else if (w_size == SzWord) begin
      w_lane = 2'b00;
    end
  end

  always_comb begin
    w_wstrb       = '0;
    w_wdata_lanes = i_wdata;
    case (w_size)
      SzByte: begin
        w_wstrb       = 4'b0001 << w_lane;
        w_wdata_lanes = {4{i_wdata[7:0]}};
      end
      SzHalf: begin
        w_wstrb       = 4'b0011 << {w_lane[1], 1'b0};
        w_wdata_lanes = {2{i_wdata[15:0]}};
      end
      SzWord: begin
        w_wstrb       = 4'b1111;
        w_wdata_lanes = i_wdata;
      end
      default: begin
        w_wstrb       = '0;
        w_wdata_lanes = i_wdata;
      end
    endcase
  end

  always_comb begin
    w_rd_byte = i_mem_rdata[7:0];
    case (r_lane)
      2'd0:    w_rd_byte = i_mem_rdata[7:0];
      2'd1:    w_rd_byte = i_mem_rdata[15:8];
      2'd2:    w_rd_byte = i_mem_rdata[23:16];
      default: w_rd_byte = i_mem_rdata[31:24];
    endcase
    w_rd_half = r_lane[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    case (r_size)
      SzByte:  w_load_data = {{24{w_rd_byte[7]}}, w_rd_byte};
      SzHalf:  w_load_data = {{16{w_rd_half[15]}}, w_rd_half};
      default: w_load_data = i_mem_rdata;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_nxt = w_skip_bus ? StResp : StBusReq;
        end
      end
      StBusReq: begin
        if (i_mem_req_ready) w_state_nxt = StBusWait;
      end
      StBusWait: begin
        if (i_mem_rvalid) w_state_nxt = StResp;
      end
      StResp: begin
        if (i_resp_ready) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_is_rd         <= 1'b0;
      r_size          <= 2'b00;
      r_lane          <= 2'b00;
      r_resp_valid    <= 1'b0;
      r_rdata         <= '0;
      r_err           <= 1'b0;
      r_mem_req_valid <= 1'b0;
      r_mem_we        <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_wdata     <= '0;
      r_mem_wstrb     <= '0;
    end else begin
      if (w_accept) begin
        r_err        <= w_illegal || w_misalign_err;
        r_rdata      <= '0;
        r_resp_valid <= w_skip_bus;
        if (!w_skip_bus) begin
          r_is_rd         <= w_is_rd;
          r_size          <= w_size;
          r_lane          <= w_lane;
          r_mem_req_valid <= 1'b1;
          r_mem_we        <= !w_is_rd;
          r_mem_addr      <= {i_addr[ADDR_W-1:2], 2'b00};
          r_mem_wdata     <= w_is_rd ? '0 : w_wdata_lanes;
          r_mem_wstrb     <= w_is_rd ? '0 : w_wstrb;
        end
      end
      if ((r_state == StBusReq) && i_mem_req_ready) begin
        r_mem_req_valid <= 1'b0;
      end
      if ((r_state == StBusWait) && i_mem_rvalid) begin
        r_resp_valid <= 1'b1;
        if (r_is_rd) r_rdata <= w_load_data;
      end
      if ((r_state == StResp) && i_resp_ready) begin
        r_resp_valid <= 1'b0;
      end
    end
  end

  assign o_req_ready     = (r_state == StIdle);
  assign o_resp_valid    = r_resp_valid;
  assign o_rdata         = r_rdata;
  assign o_resp_err      = r_err;
  assign o_mem_req_valid = r_mem_req_valid;
  assign o_mem_we        = r_mem_we;
  assign o_mem_addr      = r_mem_addr;
  assign o_mem_wdata     = r_mem_wdata;
  assign o_mem_wstrb     = r_mem_wstrb;

endmodule
